// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: program memory load, sequential (opcode, operand) issue, jump/stall/halt

module instruction_fetch #(
  parameter int ADDR_W     = 4,
  parameter int PROG_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              load_valid,
  input  logic [2:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run,
  input  logic              stall,
  input  logic              jump_taken,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [2:0]        opcode,
  output logic [2:0]        operand,
  output logic [ADDR_W-1:0] instr_ptr_if_reg,
  output logic              instr_valid,
  output logic              halt,
  output logic [ADDR_W:0]   prog_len
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_RUN, S_DONE} state_t;

  state_t            state, state_next;
  logic [2:0]        mem [PROG_DEPTH];
  logic [ADDR_W-1:0] ip, wr_ptr;
  logic [ADDR_W:0]   ip_plus1;
  logic              load_fire, load_end, run_go, load_go, at_end, advance;

  assign load_fire = (state == S_LOAD) && load_valid && load_ready;
  assign load_end  = load_fire && (load_last || wr_ptr == ADDR_W'(PROG_DEPTH - 1));
  assign run_go    = ((state == S_READY) || (state == S_DONE)) && run;
  assign load_go   = ((state == S_IDLE) || (state == S_READY) || (state == S_DONE))
                     && start_load && !run_go;
  // End test is done one bit wider so IP+1 never wraps back under prog_len.
  assign ip_plus1  = {1'b0, ip} + (ADDR_W + 1)'(1);
  assign at_end    = ip_plus1 >= prog_len;
  assign advance   = (state == S_RUN) && !jump_taken && !stall;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:          if (load_go) state_next = S_LOAD;
      S_LOAD:          if (load_end) state_next = S_READY;
      S_READY, S_DONE: begin
        if (run_go)       state_next = S_RUN;
        else if (load_go) state_next = S_LOAD;
      end
      S_RUN:           if (advance && at_end) state_next = S_DONE;
      default:         state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && load_fire) mem[wr_ptr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ip               <= '0;
      wr_ptr           <= '0;
      prog_len         <= '0;
      opcode           <= '0;
      operand          <= '0;
      instr_ptr_if_reg <= '0;
      instr_valid      <= 1'b0;
      halt             <= 1'b0;
      load_ready       <= 1'b0;
    end else begin
      if (load_go) begin
        wr_ptr     <= '0;
        load_ready <= 1'b1;
        halt       <= 1'b0;
      end
      if (load_fire) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (load_end) begin
          prog_len   <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
          load_ready <= 1'b0;
        end
      end
      if (run_go) begin
        ip          <= '0;
        halt        <= 1'b0;
        instr_valid <= 1'b0;
      end
      // Jump beats stall; a stall holds every fetch output including instr_valid.
      if (state == S_RUN && jump_taken) begin
        ip          <= jump_target;
        instr_valid <= 1'b0;
      end else if (advance) begin
        if (at_end) begin
          halt        <= 1'b1;
          instr_valid <= 1'b0;
        end else begin
          opcode           <= mem[ip];
          operand          <= mem[ip_plus1[ADDR_W-1:0]];
          instr_ptr_if_reg <= ip;
          instr_valid      <= 1'b1;
          ip               <= ip + ADDR_W'(2);
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized checks of instruction_fetch against a queue-based model

module tb_instruction_fetch;

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_READY = 2, PH_RUN = 3, PH_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_load = 1'b0, load_valid = 1'b0, load_last = 1'b0, load_ready;
  logic [2:0] load_data = 3'd0;
  logic       run = 1'b0, stall = 1'b0, jump_taken = 1'b0;
  logic [3:0] jump_target = 4'd0;
  logic [2:0] opcode, operand;
  logic [3:0] instr_ptr_if_reg;
  logic       instr_valid, halt;
  logic [4:0] prog_len;

  int n_vec = 0;
  int n_bad = 0;

  instruction_fetch #(.ADDR_W(4), .PROG_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .start_load(start_load), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .run(run), .stall(stall), .jump_taken(jump_taken), .jump_target(jump_target),
    .opcode(opcode), .operand(operand), .instr_ptr_if_reg(instr_ptr_if_reg),
    .instr_valid(instr_valid), .halt(halt), .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
  endtask

  // Model: the program is a queue of words; an instruction is the pair at (ip, ip+1).
  int         ph;
  int         m_ip;
  logic [2:0] prog[$];
  logic [2:0] fresh[$];
  int         x_op, x_opd, x_ip, x_v, x_halt, x_rdy;
  bit         model_live = 1'b0;

  task automatic model_begin_load();
    ph = PH_LOAD;
    fresh.delete();
    x_rdy  = 1;
    x_halt = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      ph = PH_IDLE; m_ip = 0; prog.delete(); fresh.delete();
      x_op = 0; x_opd = 0; x_ip = 0; x_v = 0; x_halt = 0; x_rdy = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      case (ph)
        PH_IDLE: if (start_load) model_begin_load();
        PH_LOAD: if (load_valid) begin
          fresh.push_back(load_data);
          if (load_last || fresh.size() == 16) begin
            prog  = fresh;
            x_rdy = 0;
            ph    = PH_READY;
          end
        end
        PH_READY, PH_DONE: begin
          if (run) begin
            ph = PH_RUN; m_ip = 0; x_halt = 0; x_v = 0;
          end else if (start_load) begin
            model_begin_load();
          end
        end
        PH_RUN: begin
          if (jump_taken) begin
            m_ip = int'(jump_target);
            x_v  = 0;
          end else if (!stall) begin
            if (m_ip + 1 >= prog.size()) begin
              x_halt = 1; x_v = 0; ph = PH_DONE;
            end else begin
              x_op = int'(prog[m_ip]); x_opd = int'(prog[m_ip + 1]);
              x_ip = m_ip; x_v = 1; m_ip += 2;
            end
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("opcode", int'(opcode), x_op);
      check("operand", int'(operand), x_opd);
      check("instr_ptr", int'(instr_ptr_if_reg), x_ip);
      check("instr_valid", int'(instr_valid), x_v);
      check("halt", int'(halt), x_halt);
      check("load_ready", int'(load_ready), x_rdy);
      check("prog_len", int'(prog_len), prog.size());
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [2:0] wq[$];

  task automatic load_words(input bit with_last);
    start_load = 1'b1; step(); start_load = 1'b0;
    foreach (wq[i]) begin
      load_valid = 1'b1;
      load_data  = wq[i];
      load_last  = with_last && (i == wq.size() - 1);
      step();
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic expect_instr(input string tag, input int op, input int opd, input int ipv);
    check({tag, "_op"}, int'(opcode), op);
    check({tag, "_opd"}, int'(operand), opd);
    check({tag, "_ip"}, int'(instr_ptr_if_reg), ipv);
    check({tag, "_valid"}, int'(instr_valid), 1);
  endtask

  task automatic run_to_end(input string tag, input int budget);
    int k = 0;
    while (ph == PH_RUN && k < budget) begin step(); k++; end
    if (ph == PH_RUN) bound_fail(tag);
  endtask

  task automatic clear_inputs();
    start_load = 1'b0; load_valid = 1'b0; load_last = 1'b0; run = 1'b0;
    stall = 1'b0; jump_taken = 1'b0; rst = 1'b0;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    check("rst_prog_len", int'(prog_len), 0);
    check("rst_load_ready", int'(load_ready), 0);
    check("rst_valid", int'(instr_valid), 0);
    check("rst_halt", int'(halt), 0);

    // Six-word program, three back-to-back instructions then halt.
    wq = {3'd2, 3'd4, 3'd1, 3'd1, 3'd7, 3'd5};
    start_load = 1'b1; step(); start_load = 1'b0;
    check("t1_ready_open", int'(load_ready), 1);
    foreach (wq[i]) begin
      load_valid = 1'b1; load_data = wq[i]; load_last = (i == 5); step();
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("t1_ready_closed", int'(load_ready), 0);
    check("t1_prog_len", int'(prog_len), 6);
    run = 1'b1; step(); run = 1'b0;
    check("t1_entry_valid", int'(instr_valid), 0);
    step(); expect_instr("t1_c1", 2, 4, 0);
    step(); expect_instr("t1_c2", 1, 1, 2);
    step(); expect_instr("t1_c3", 7, 5, 4);
    step();
    check("t1_halt", int'(halt), 1);
    check("t1_end_valid", int'(instr_valid), 0);

    // Stall freeze, then jump back to 0 with a single bubble.
    wq = {3'd0, 3'd3, 3'd5, 3'd4, 3'd3, 3'd0};
    load_words(1'b1);
    run = 1'b1; step(); run = 1'b0;
    step(); expect_instr("t2_c1", 0, 3, 0);
    step(); expect_instr("t2_c2", 5, 4, 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); expect_instr("t2_stall", 5, 4, 2); end
    stall = 1'b0;
    step(); expect_instr("t2_resume", 3, 0, 4);
    jump_taken = 1'b1; jump_target = 4'd0;
    step(); jump_taken = 1'b0;
    check("t2_bubble", int'(instr_valid), 0);
    step(); expect_instr("t2_after_jump", 0, 3, 0);
    run_to_end("t2_run", 20);

    // Jump and stall together; odd length halts before the lone trailing word.
    wq = {3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    load_words(1'b1);
    check("t3_prog_len", int'(prog_len), 5);
    run = 1'b1; step(); run = 1'b0;
    step(); expect_instr("t3_c1", 1, 2, 0);
    jump_taken = 1'b1; stall = 1'b1; jump_target = 4'd2;
    step(); jump_taken = 1'b0; stall = 1'b0;
    check("t3_bubble", int'(instr_valid), 0);
    step(); expect_instr("t3_c2", 3, 4, 2);
    step();
    check("t3_halt", int'(halt), 1);
    check("t3_no_ip4", int'(instr_ptr_if_reg), 2);

    // Reset in the middle of a load, then run must be ignored.
    wq = {3'd7, 3'd7, 3'd7};
    load_words(1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    check("t4_prog_len", int'(prog_len), 0);
    check("t4_load_ready", int'(load_ready), 0);
    check("t4_halt", int'(halt), 0);
    run = 1'b1; step(); run = 1'b0; step();
    check("t4_run_ignored", int'(instr_valid), 0);
    wq = {3'd6, 3'd1};
    load_words(1'b1);
    run = 1'b1; step(); run = 1'b0;
    step(); expect_instr("t4_reload", 6, 1, 0);
    run_to_end("t4_run", 20);

    // Randomized loads and runs; the compare process checks every cycle.
    for (int it = 0; it < 40; it++) begin
      int n = $urandom_range(1, 16);
      bit wl = ($urandom % 4) != 0;
      int k = 0;
      start_load = 1'b1; step(); start_load = 1'b0;
      while (ph == PH_LOAD && k < 200) begin
        load_valid = ($urandom % 3) != 0;
        load_data  = 3'($urandom);
        load_last  = wl && (fresh.size() == n - 1);
        run        = ($urandom % 16) == 0;
        start_load = ($urandom % 16) == 0;
        rst        = ($urandom % 60) == 0;
        step(); k++;
      end
      clear_inputs();
      if (ph == PH_LOAD) bound_fail("rand_load");
      run = 1'b1; step(); run = 1'b0;
      k = 0;
      while (ph == PH_RUN && k < 100) begin
        stall       = (k < 50) && (($urandom % 4) == 0);
        jump_taken  = (k < 50) && (($urandom % 8) == 0);
        jump_target = 4'($urandom_range(0, 7));
        start_load  = ($urandom % 16) == 0;
        run         = ($urandom % 16) == 0;
        step(); k++;
      end
      clear_inputs();
      if (ph == PH_RUN) bound_fail("rand_run");
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
